icache_dm: RTL
==============

ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 SHALL have parameter LINES, default 16, meaning number of cache lines (power of two, 2..256).
REQ-002 SHALL have parameter WORDS, default 4, meaning 32-bit words per line (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cpu_addr_i  input  32  fetch byte address from the core PC.
REQ-006 SHALL have port cpu_ce_i  input  1  fetch enable from the core.
REQ-007 SHALL have port cpu_inst_o  output  32  instruction returned to the core IF/ID register.
REQ-008 SHALL have port cpu_stall_o  output  1  high while the fetch cannot be served this cycle.
REQ-009 SHALL have port flush_i  input  1  invalidate all lines (fence.i / program reload).
REQ-010 SHALL have port mem_req_o  output  1  backing-memory word read request.
REQ-011 SHALL have port mem_addr_o  output  32  word-aligned backing-memory byte address.
REQ-012 SHALL have port mem_ack_i  input  1  backing memory returns mem_data_i this cycle.
REQ-013 SHALL have port mem_data_i  input  32  backing-memory read data.

Function
REQ-014 SHALL split cpu_addr_i as: bits[1:0] ignored, word offset next log2(WORDS) bits, index next log2(LINES) bits, tag = remaining upper bits (defaults: word [3:2], index [7:4], tag [31:8]).
REQ-015 SHALL store per line: valid bit, tag, WORDS data words.
REQ-016 SHALL compute hit combinationally: cpu_ce_i & state IDLE & valid[index] & tag match.
REQ-017 SHALL on hit drive cpu_inst_o = stored word, cpu_stall_o = 0, same cycle (zero-latency hit).
REQ-018 SHALL on cpu_ce_i = 0 drive cpu_inst_o = 32'h00000013 (NOP), cpu_stall_o = 0, no state change.
REQ-019 SHALL on miss (cpu_ce_i & no hit) drive cpu_inst_o = NOP, cpu_stall_o = 1, latch tag/index, go IDLE -> FILL next edge.
REQ-020 SHALL in FILL drive mem_req_o = 1, mem_addr_o = {tag, index, cnt, 2'b00}, cnt starting 0 and incrementing linearly.
REQ-021 SHALL hold mem_req_o and mem_addr_o stable until mem_ack_i; on each ack write mem_data_i to word cnt and increment cnt.
REQ-022 SHALL on ack of word WORDS-1 write tag, set valid (unless flush occurred during fill), deassert mem_req_o, return to IDLE next edge.
REQ-023 SHALL keep cpu_stall_o = 1 and cpu_inst_o = NOP in every cycle the FSM is in FILL; the retried fetch hits in the first IDLE cycle.
REQ-024 SHALL ignore mem_ack_i when not in FILL.
REQ-025 SHALL on flush_i in IDLE clear all valid bits next edge; a fetch in that same cycle is treated as a miss.
REQ-026 SHALL on flush_i during FILL clear all valid bits, complete the fill, and not set valid for the filled line.
REQ-027 SHALL use the latched tag/index during FILL regardless of cpu_addr_i changes.
REQ-028 SHALL drive mem_addr_o = 0 when mem_req_o = 0.

Reset
REQ-029 SHALL on rst clear all valid bits, FSM = IDLE, cnt = 0, mem_req_o = 0, mem_addr_o = 0, statistics counters = 0; data/tag arrays need not reset.
REQ-030 SHALL abort an in-progress fill on rst mid-operation; the partially filled line stays invalid.

Configuration
REQ-031 SHALL with macro ICACHE_STATS_EN defined add outputs hit_cnt_o (output, 32, count of hit cycles) and miss_cnt_o (output, 32, count of fills started), both wrapping at 2^32 and cleared by rst or flush_i.
REQ-032 SHALL without ICACHE_STATS_EN omit these ports and counters entirely.

Verification
REQ-033 SHALL cover cold miss: rst, fetch 0x00000000, ack one cycle after each req with 0x11,0x22,0x33,0x44 -> stall 1 for 4+ cycles, req addrs 0x0,0x4,0x8,0xC, then inst 0x11 stall 0.
REQ-034 SHALL cover hit: after REQ-033 fetch 0x00000008 -> inst 0x33 same cycle, stall 0, mem_req_o 0.
REQ-035 SHALL cover conflict: fetch 0x00000100 (same index 0, tag 1) -> refill of line 0, subsequent 0x00000000 misses again.
REQ-036 SHALL cover slow memory: ack delayed 3 cycles per word -> mem_req_o/mem_addr_o held stable, stall held, correct data.
REQ-037 SHALL cover flush during FILL at word 2 -> fill completes, retried fetch misses and refills.
REQ-038 SHALL cover rst asserted mid-fill -> mem_req_o 0 immediately, next fetch of that line misses; with ICACHE_STATS_EN counts match hits/misses.

Source files
------------

// File: rtl/icache_dm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | icache_dm : direct-mapped instruction cache, zero-latency hit, word fill |
// | Optional ICACHE_STATS_EN adds hit/miss counters.           Rev 1.0       |
// +--------------------------------------------------------------------------+
module icache_dm #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr_i,
  input  logic        cpu_ce_i,
  output logic [31:0] cpu_inst_o,
  output logic        cpu_stall_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int WB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TB = 32 - IB - WB - 2;
  localparam logic [31:0] C_NOP = 32'h0000_0013;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TB-1:0]    fill_tag_q, fill_tag_d;
  logic [IB-1:0]    fill_idx_q, fill_idx_d;
  logic [WB-1:0]    cnt_q, cnt_d;
  logic             flushed_q, flushed_d;

  logic [31:0]      data_q [LINES*WORDS];
  logic [TB-1:0]    tag_q  [LINES];

  logic [TB-1:0]    req_tag;
  logic [IB-1:0]    req_idx;
  logic [WB-1:0]    req_word;
  logic             hit;
  logic             fill_start;
  logic             fill_ack;
  logic             last_ack;
  logic             unused_addr_bits;

  assign req_word         = cpu_addr_i[2 +: WB];
  assign req_idx          = cpu_addr_i[2 + WB +: IB];
  assign req_tag          = cpu_addr_i[31 -: TB];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  // A flush in the same cycle forces a miss so stale lines are never returned.
  assign hit        = cpu_ce_i && (state_q == S_IDLE) && !flush_i &&
                      valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign fill_start = (state_q == S_IDLE) && cpu_ce_i && !hit;
  assign fill_ack   = (state_q == S_FILL) && mem_ack_i;
  assign last_ack   = fill_ack && (&cnt_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fill_start) state_d = S_FILL;
      S_FILL:  if (last_ack)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_inst_o  = C_NOP;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    case (state_q)
      S_IDLE: begin
        if (hit) cpu_inst_o = data_q[{req_idx, req_word}];
        cpu_stall_o = cpu_ce_i && !hit;
      end
      S_FILL: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = {fill_tag_q, fill_idx_q, cnt_q, 2'b00};
      end
      default: ;
    endcase
  end

  // A flush seen at any point of a fill keeps the refilled line invalid.
  always_comb begin
    valid_d    = valid_q;
    fill_tag_d = fill_tag_q;
    fill_idx_d = fill_idx_q;
    cnt_d      = cnt_q;
    flushed_d  = flushed_q;
    if (fill_start) begin
      fill_tag_d = req_tag;
      fill_idx_d = req_idx;
      cnt_d      = '0;
      flushed_d  = 1'b0;
    end
    if (state_q == S_FILL) begin
      if (mem_ack_i) cnt_d = cnt_q + 1'b1;
      if (flush_i)   flushed_d = 1'b1;
      if (last_ack && !flushed_q && !flush_i) valid_d[fill_idx_q] = 1'b1;
    end
    if (flush_i) valid_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      fill_tag_q <= '0;
      fill_idx_q <= '0;
      cnt_q      <= '0;
      flushed_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      fill_tag_q <= fill_tag_d;
      fill_idx_q <= fill_idx_d;
      cnt_q      <= cnt_d;
      flushed_q  <= flushed_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_ack) begin
      data_q[{fill_idx_q, cnt_q}] <= mem_data_i;
      if (last_ack) tag_q[fill_idx_q] <= fill_tag_q;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (flush_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit)        hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (fill_start) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
`default_nettype wire
